srambank_ctrl_256x4x20: RTL and testbench

Request/response front end for the 1024×20 synchronous SRAM bank (`srambank_256x4x20_6t122`).
- Accepts read/write requests on a valid/ready channel and drives the bank's `banksel`/`read`/`write`/`ADDRESS`/`wd` pins.
- Captures the bank's `dataout` one cycle after each read and returns it, in order, through a buffered valid/ready response channel.
- Sits directly upstream of the bank. The bank itself is instantiated alongside, not inside, this block.

---
 rtl/srambank_pkg.sv | 18 +
 rtl/srambank_rsp_fifo.sv | 67 ++++++
 rtl/srambank_ctrl_256x4x20.sv | 70 +++++++
 tb/tb_srambank_ctrl_256x4x20.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/srambank_pkg.sv
// Shared constants, request type and pointer helper for the 1024x20 SRAM bank front end.
package srambank_pkg;

    localparam int unsigned SRAM_ADDR_W = 10;
    localparam int unsigned SRAM_DATA_W = 20;

    typedef struct packed {
        logic                   write;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } srambank_req_t;

    // Explicit wrap compare so non-power-of-2 depths work.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/srambank_rsp_fifo.sv
// Response FIFO: in-order buffer for read data; control state is reset, storage is not.
module srambank_rsp_fifo
    import srambank_pkg::*;
#(
    parameter int unsigned DATA_W = SRAM_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o,
    output logic [DATA_W-1:0]          head_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            wr_ptr_d = PtrW'(wrap_inc(32'(wr_ptr_q), DEPTH));
        end
        if (pop_i) begin
            rd_ptr_d = PtrW'(wrap_inc(32'(rd_ptr_q), DEPTH));
        end
        unique case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = mem_q[rd_ptr_q];

    // Upstream credit accounting must never let a push land on a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && (cnt_q == CntW'(DEPTH))));

endmodule

// File: rtl/srambank_ctrl_256x4x20.sv
// Request/response front end for the 1024x20 SRAM bank: drives bank pins, buffers read data.
module srambank_ctrl_256x4x20
    import srambank_pkg::*;
#(
    parameter int unsigned ADDR_W    = SRAM_ADDR_W,
    parameter int unsigned DATA_W    = SRAM_DATA_W,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic [DATA_W-1:0] wd,
    output logic              banksel,
    output logic              read,
    output logic              write,
    input  logic [DATA_W-1:0] dataout,
    output logic              idle
);

    localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

    logic            acc;
    logic            rd_pend_q, rd_pend_d;
    logic [CntW-1:0] cnt;

    always_comb begin
        // Credits count buffered data plus the read whose data arrives this cycle.
        req_ready = (32'(cnt) + 32'(rd_pend_q)) < RSP_DEPTH;
        // req_ready stays high during reset, so the bank is kept quiet by gating here.
        acc       = req_valid & req_ready & rst_n;
        banksel   = acc;
        read      = acc & ~req_write;
        write     = acc & req_write;
        ADDRESS   = req_addr;
        wd        = req_wdata;
        rd_pend_d = acc & ~req_write;
        rsp_valid = (cnt != '0);
        idle      = ~rd_pend_q & (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    srambank_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rd_pend_q),
        .push_data_i (dataout),
        .pop_i       (rsp_valid & rsp_ready),
        .cnt_o       (cnt),
        .head_o      (rsp_rdata)
    );

endmodule

// File: tb/tb_srambank_ctrl_256x4x20.sv
// Directed bench for srambank_ctrl_256x4x20 with a behavioural bank and response scoreboard.
module tb_srambank_ctrl_256x4x20;
    import srambank_pkg::*;

    localparam int unsigned ADDR_W    = SRAM_ADDR_W;
    localparam int unsigned DATA_W    = SRAM_DATA_W;
    localparam int unsigned RSP_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] ADDRESS;
    logic [DATA_W-1:0] wd;
    logic              banksel, read, write;
    logic [DATA_W-1:0] dataout;
    logic              idle;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    srambank_ctrl_256x4x20 #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ADDRESS   (ADDRESS),
        .wd        (wd),
        .banksel   (banksel),
        .read      (read),
        .write     (write),
        .dataout   (dataout),
        .idle      (idle)
    );

    // Behavioural bank: synchronous write, registered read data.
    logic [DATA_W-1:0] bank_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (banksel && write) bank_mem[ADDRESS] <= wd;
        if (banksel && read)  dataout <= bank_mem[ADDRESS];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference memory and scoreboard.
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] exp_q [$];
    int acc_cnt = 0, pop_cnt = 0, cyc = 0, first_pop = 0, last_pop = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("rw_exclusive", 32'(read & write), 0);
            chk("banksel", 32'(banksel), 32'(req_valid & req_ready));
            if (banksel) begin
                chk("bank_addr", 32'(ADDRESS), 32'(req_addr));
                chk("bank_wd", 32'(wd), 32'(req_wdata));
            end
            if (req_valid && req_ready) begin
                acc_cnt++;
                if (req_write) ref_mem[req_addr] = req_wdata;
                else exp_q.push_back(ref_mem[req_addr]);
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
                if (pop_cnt == 0) first_pop = cyc;
                last_pop = cyc;
                pop_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input srambank_req_t r);
        req_valid = 1'b1;
        req_write = r.write;
        req_addr  = r.addr;
        req_wdata = r.wdata;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!idle && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(idle), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_banksel", 32'(banksel), 0);
        chk("rst_rw", 32'({read, write}), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_req_ready", 32'(req_ready), 1);

        // Write then read the same word on the next cycle.
        step();
        rst_n = 1'b1;
        set_req('{write: 1'b1, addr: 10'h3FF, wdata: 20'hABCDE});
        #1;
        chk("first_accept", 32'(banksel & write), 1);
        step();
        set_req('{write: 1'b0, addr: 10'h3FF, wdata: 20'h0});
        @(negedge clk);
        chk("wr_rd_accept", 32'(read), 1);
        chk("wr_rd_valid_t0", 32'(rsp_valid), 0);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("wr_rd_valid_t1", 32'(rsp_valid), 0);
        chk("wr_rd_idle_t1", 32'(idle), 0);
        step();
        @(negedge clk);
        chk("wr_rd_valid_t2", 32'(rsp_valid), 1);
        chk("wr_rd_data", 32'(rsp_rdata), 32'h000ABCDE);
        step();
        @(negedge clk);
        chk("wr_rd_idle_end", 32'(idle), 1);

        // Preload addresses 0..15 with addr*3.
        step();
        for (int i = 0; i < 16; i++) begin
            set_req('{write: 1'b1, addr: 10'(i), wdata: 20'(i * 3)});
            @(negedge clk);
            chk("preload_ready", 32'(req_ready), 1);
            step();
        end
        req_valid = 1'b0;

        // Streaming reads with rsp_ready held high.
        acc_cnt = 0;
        pop_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            set_req('{write: 1'b0, addr: 10'(i), wdata: 20'h0});
            @(negedge clk);
            chk("stream_ready", 32'(req_ready), 1);
            step();
        end
        req_valid = 1'b0;
        wait_idle();
        chk("stream_accepts", 32'(acc_cnt), 16);
        chk("stream_pops", 32'(pop_cnt), 16);
        chk("stream_gapless", 32'(last_pop - first_pop), 15);

        // Fill to full credit, then push and pop on the same edge.
        step();
        rsp_ready = 1'b0;
        acc_cnt   = 0;
        pop_cnt   = 0;
        for (int i = 0; i < 4; i++) begin
            set_req('{write: 1'b0, addr: 10'(4 + i), wdata: 20'h0});
            @(negedge clk);
            chk("full_ready", 32'(req_ready), 1);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("full_credit_ready", 32'(req_ready), 0);
        chk("full_credit_valid", 32'(rsp_valid), 1);
        step();
        @(negedge clk);
        chk("pushpop_ready", 32'(req_ready), 1);
        chk("pushpop_valid", 32'(rsp_valid), 1);
        wait_idle();
        chk("pushpop_pops", 32'(pop_cnt), 4);
        chk("pushpop_accepts", 32'(acc_cnt), 4);

        // Backpressure: only RSP_DEPTH reads get in.
        step();
        rsp_ready = 1'b0;
        acc_cnt   = 0;
        pop_cnt   = 0;
        for (int i = 0; i < 7; i++) begin
            set_req('{write: 1'b0, addr: 10'(8 + i), wdata: 20'h0});
            step();
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepts", 32'(acc_cnt), RSP_DEPTH);
        chk("bp_ready_low", 32'(req_ready), 0);
        chk("bp_no_pops", 32'(pop_cnt), 0);
        step();
        rsp_ready = 1'b1;
        wait_idle();
        chk("bp_pops", 32'(pop_cnt), RSP_DEPTH);
        chk("bp_ready_back", 32'(req_ready), 1);

        // Reset with two responses buffered and one read pending.
        step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req('{write: 1'b0, addr: 10'(5 + i), wdata: 20'h0});
            step();
        end
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_idle", 32'(idle), 1);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst_ready", 32'(req_ready), 1);
        rsp_ready = 1'b1;
        pop_cnt   = 0;
        set_req('{write: 1'b0, addr: 10'd5, wdata: 20'h0});
        step();
        req_valid = 1'b0;
        wait_idle();
        chk("midrst_reread_pops", 32'(pop_cnt), 1);
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
